// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
// Shares the single register-file write port between the EXU and LSU write-back
// paths and keeps a per-register busy scoreboard that stalls issue on RAW/WAW
// hazards against writes that have been reserved but not yet committed.
//
// Optional build macro: RF_WB_ERRCHK_EN
//   When defined, a sticky wb_err output flags write-backs to registers that were
//   never reserved, and cycles where both requesters target the same register.

module regfile_wb_scheduler #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  issue_valid,
   output logic                  issue_ready,
   input  logic                  issue_wen,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   input  logic [ADDR_WIDTH-1:0] issue_rs1,
   input  logic [ADDR_WIDTH-1:0] issue_rs2,
   input  logic                  exu_valid,
   output logic                  exu_ready,
   input  logic [ADDR_WIDTH-1:0] exu_rd,
   input  logic [DATA_WIDTH-1:0] exu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   output logic                  rf_valid,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  idle
`ifdef RF_WB_ERRCHK_EN
   ,
   output logic                  wb_err
`endif
);

   localparam int NUM_REGS = 1 << ADDR_WIDTH;

   // Which requester held the write port most recently; the other one wins a tie.
   typedef enum logic {
      GRANT_EXU = 1'b0,
      GRANT_LSU = 1'b1
   } grant_e;

   logic [NUM_REGS-1:0]   busy_q, busy_d;
   grant_e                last_grant_q, last_grant_d;
   logic                  rf_valid_q, rf_valid_d;
   logic                  rf_wen_q, rf_wen_d;
   logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

   logic                  grant_exu;
   logic                  grant_lsu;
   logic                  grant_any;
   logic [ADDR_WIDTH-1:0] wb_rd;
   logic [DATA_WIDTH-1:0] wb_data;
   logic                  issue_fire;
   logic                  commit_write;

   // Hazard check: sources must not be pending, and the destination must not be
   // pending either (WAW), so a register is never reserved twice.
   always_comb begin
      issue_ready = ~busy_q[issue_rs1] & ~busy_q[issue_rs2] & ~(issue_wen & busy_q[issue_rd]);
      issue_fire  = issue_valid & issue_ready & issue_wen & (issue_rd != '0);
   end

   // Round-robin arbitration; a lone requester always wins, a tie goes to the one
   // that did not win last time. Ready is only ever raised alongside its valid.
   always_comb begin
      grant_exu = exu_valid & (~lsu_valid | (last_grant_q == GRANT_LSU));
      grant_lsu = lsu_valid & (~exu_valid | (last_grant_q == GRANT_EXU));
      grant_any = grant_exu | grant_lsu;
      exu_ready = grant_exu;
      lsu_ready = grant_lsu;
      wb_rd     = grant_lsu ? lsu_rd : exu_rd;
      wb_data   = grant_lsu ? lsu_data : exu_data;
   end

   // Remember the most recent winner; hold it through cycles without a grant.
   always_comb begin
      last_grant_d = last_grant_q;
      if (grant_exu) begin
         last_grant_d = GRANT_EXU;
      end else if (grant_lsu) begin
         last_grant_d = GRANT_LSU;
      end
   end

   // Write stage: a granted request is presented to the register file one cycle
   // later. Address and data hold when idle so the port does not toggle needlessly.
   always_comb begin
      rf_valid_d = grant_any;
      rf_wen_d   = grant_any & (wb_rd != '0);
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (grant_any) begin
         rf_waddr_d = wb_rd;
         rf_wdata_d = wb_data;
      end
   end

   // Scoreboard update: the register file captures the data at the same edge the
   // busy bit clears, so a dependent instruction issuing afterwards reads fresh
   // data. A reservation in the same cycle as a clear of the same index wins.
   always_comb begin
      commit_write = rf_valid_q & rf_wen_q;
      busy_d       = busy_q;
      if (commit_write) begin
         busy_d[rf_waddr_q] = 1'b0;
      end
      if (issue_fire) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // State registers; reset drops any pending write and forgets all reservations.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_q       <= '0;
         last_grant_q <= GRANT_LSU;
         rf_valid_q   <= 1'b0;
         rf_wen_q     <= 1'b0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
      end else begin
         busy_q       <= busy_d;
         last_grant_q <= last_grant_d;
         rf_valid_q   <= rf_valid_d;
         rf_wen_q     <= rf_wen_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
      end
   end

   // Drive the register-file port and the idle indication from registered state.
   always_comb begin
      rf_valid = rf_valid_q;
      rf_wen   = rf_wen_q;
      rf_waddr = rf_waddr_q;
      rf_wdata = rf_wdata_q;
      idle     = (busy_q == '0) & ~rf_valid_q;
   end

`ifdef RF_WB_ERRCHK_EN
   logic wb_err_q, wb_err_d;
   logic unreserved_write;
   logic same_rd_conflict;

   // Flag writes to registers nobody reserved, and both paths racing for one
   // register; once raised the flag stays until reset.
   always_comb begin
      unreserved_write = grant_any & (wb_rd != '0) & ~busy_q[wb_rd];
      same_rd_conflict = exu_valid & lsu_valid & (exu_rd == lsu_rd) & (exu_rd != '0);
      wb_err_d         = wb_err_q | unreserved_write | same_rd_conflict;
   end

   // Sticky error register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wb_err_q <= 1'b0;
      end else begin
         wb_err_q <= wb_err_d;
      end
   end

   assign wb_err = wb_err_q;
`endif

endmodule
